// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback queue: the queued entry layout and
// the forwarding address-match rule.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Register 0 is hard-wired, so it never produces a forwarding hit.
    function automatic logic fwd_match(input wb_entry_t entry,
                                       input logic [REG_ADDR_W-1:0] addr);
        return (addr != '0) && (entry.reg_addr == addr);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular entry store with two ordered write ports and one pop port; exposes all
// entries oldest-first so the forwarding search can walk them by age.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr0_en,
    input  wb_entry_t             wr0_entry,
    input  logic                  wr1_en,
    input  wb_entry_t             wr1_entry,
    input  logic                  pop,
    output logic [CNT_W-1:0]      count,
    output wb_entry_t [DEPTH-1:0] slots
);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             pop_ok;
    wb_entry_t        store [DEPTH];

    assign pop_ok = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_ok);
            tail  <= tail + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            count <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop_ok);
        end
    end

    // Port 0 is the older request, so port 1 lands one slot behind it when both write.
    always_ff @(posedge clk) begin
        if (wr0_en) begin
            store[tail] <= wr0_entry;
        end
        if (wr1_en) begin
            store[tail + PTR_W'(wr0_en)] <= wr1_entry;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slots[PTR_W'(i)] = store[head + PTR_W'(i)];
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback buffer: merges load and ALU write requests, retires one
// per cycle through a registered write port, and forwards the youngest pending value.
module writeback_queue #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 5,
    parameter  int DATA_W = 32,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemValid,
    input  logic [ADDR_W-1:0] MemReg,
    input  logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    input  logic              AluValid,
    input  logic [ADDR_W-1:0] AluReg,
    input  logic [DATA_W-1:0] AluData,
    output logic              AluReady,
    input  logic              Hold,
    output logic              RegWre,
    output logic [ADDR_W-1:0] WriteReg,
    output logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic              Fwd1Valid,
    output logic [DATA_W-1:0] Fwd1Data,
    output logic              Fwd2Valid,
    output logic [DATA_W-1:0] Fwd2Data,
    output logic [CNT_W-1:0]  Count
);
    import wb_pkg::*;

    logic [CNT_W-1:0]      free;
    logic                  mem_push;
    logic                  alu_push;
    logic                  pop;
    wb_entry_t             mem_entry;
    wb_entry_t             alu_entry;
    wb_entry_t [DEPTH-1:0] slots;
    logic [ADDR_W-1:0]     lookup_addr [2];
    logic                  fwd_valid   [2];
    logic [DATA_W-1:0]     fwd_data    [2];

    // Space comes from the registered count only; a same-cycle pop frees nothing.
    assign free     = CNT_W'(DEPTH) - Count;
    assign MemReady = !RST && (free != '0);
    assign AluReady = !RST && ((free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !MemValid));

    // Writes to register 0 complete the handshake but are dropped.
    assign mem_push = MemValid && MemReady && (MemReg != '0);
    assign alu_push = AluValid && AluReady && (AluReg != '0);
    assign pop      = !Hold && (Count != '0);

    assign mem_entry = '{reg_addr: MemReg, data: MemData};
    assign alu_entry = '{reg_addr: AluReg, data: AluData};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (CLK),
        .rst      (RST),
        .wr0_en   (mem_push),
        .wr0_entry(mem_entry),
        .wr1_en   (alu_push),
        .wr1_entry(alu_entry),
        .pop      (pop),
        .count    (Count),
        .slots    (slots)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            RegWre    <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
        end else if (pop) begin
            RegWre    <= 1'b1;
            WriteReg  <= slots[0].reg_addr;
            WriteData <= slots[0].data;
        end else begin
            RegWre    <= 1'b0;
        end
    end

    assign lookup_addr[0] = ReadReg1;
    assign lookup_addr[1] = ReadReg2;

    // Youngest queued entry wins; the value on the write port is the oldest candidate.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_valid[p] = 1'b0;
            fwd_data[p]  = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (!fwd_valid[p] && (CNT_W'(i) < Count) &&
                    fwd_match(slots[PTR_W'(i)], lookup_addr[p])) begin
                    fwd_valid[p] = 1'b1;
                    fwd_data[p]  = slots[PTR_W'(i)].data;
                end
            end
            if (!fwd_valid[p] && RegWre && (lookup_addr[p] != '0) &&
                (WriteReg == lookup_addr[p])) begin
                fwd_valid[p] = 1'b1;
                fwd_data[p]  = WriteData;
            end
        end
    end

    assign Fwd1Valid = fwd_valid[0];
    assign Fwd1Data  = fwd_data[0];
    assign Fwd2Valid = fwd_valid[1];
    assign Fwd2Data  = fwd_data[1];

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: one task per scenario with hand-computed
// expectations and a small occupancy model for the wrap/hold run.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    logic              CLK = 1'b0;
    logic              RST;
    logic              MemValid;
    logic [ADDR_W-1:0] MemReg;
    logic [DATA_W-1:0] MemData;
    logic              MemReady;
    logic              AluValid;
    logic [ADDR_W-1:0] AluReg;
    logic [DATA_W-1:0] AluData;
    logic              AluReady;
    logic              Hold;
    logic              RegWre;
    logic [ADDR_W-1:0] WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] ReadReg1;
    logic [ADDR_W-1:0] ReadReg2;
    logic              Fwd1Valid;
    logic [DATA_W-1:0] Fwd1Data;
    logic              Fwd2Valid;
    logic [DATA_W-1:0] Fwd2Data;
    logic [CNT_W-1:0]  Count;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    writeback_queue #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .MemValid (MemValid),
        .MemReg   (MemReg),
        .MemData  (MemData),
        .MemReady (MemReady),
        .AluValid (AluValid),
        .AluReg   (AluReg),
        .AluData  (AluData),
        .AluReady (AluReady),
        .Hold     (Hold),
        .RegWre   (RegWre),
        .WriteReg (WriteReg),
        .WriteData(WriteData),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .Fwd1Valid(Fwd1Valid),
        .Fwd1Data (Fwd1Data),
        .Fwd2Valid(Fwd2Valid),
        .Fwd2Data (Fwd2Data),
        .Count    (Count)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        MemValid = 1'b0;
        MemReg   = '0;
        MemData  = '0;
        AluValid = 1'b0;
        AluReg   = '0;
        AluData  = '0;
        Hold     = 1'b0;
        ReadReg1 = '0;
        ReadReg2 = '0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        RST = 1'b1;
        tick();
        tick();
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", Count); end
        checks++; if (RegWre !== 1'b0) begin failures++; $display("FAIL reset_regwre: got %b expected 0", RegWre); end
        checks++; if (WriteReg !== 5'd0 || WriteData !== 32'd0) begin failures++; $display("FAIL reset_wport: got %0d/%h expected 0/0", WriteReg, WriteData); end
        checks++; if (MemReady !== 1'b0 || AluReady !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b%b expected 00", MemReady, AluReady); end
        checks++; if (Fwd1Valid !== 1'b0 || Fwd2Valid !== 1'b0) begin failures++; $display("FAIL reset_fwd: got %b%b expected 00", Fwd1Valid, Fwd2Valid); end
        RST = 1'b0;
        #1;
        checks++; if (MemReady !== 1'b1 || AluReady !== 1'b1) begin failures++; $display("FAIL empty_ready: got %b%b expected 11", MemReady, AluReady); end
    endtask

    task automatic test_single_write();
        $display("[TB] test_single_write");
        MemValid = 1'b1; MemReg = 5'd5; MemData = 32'h1234;
        #1;
        checks++; if (MemReady !== 1'b1) begin failures++; $display("FAIL single_ready: got %b expected 1", MemReady); end
        tick();
        MemValid = 1'b0;
        ReadReg1 = 5'd5;
        #1;
        checks++; if (Count !== 3'd1 || RegWre !== 1'b0) begin failures++; $display("FAIL single_n1: got count %0d regwre %b expected 1/0", Count, RegWre); end
        checks++; if (Fwd1Valid !== 1'b1 || Fwd1Data !== 32'h1234) begin failures++; $display("FAIL single_fwd_queue: got %b/%h expected 1/1234", Fwd1Valid, Fwd1Data); end
        tick();
        checks++; if (RegWre !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'h1234) begin failures++; $display("FAIL single_write: got %b/%0d/%h expected 1/5/1234", RegWre, WriteReg, WriteData); end
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL single_count: got %0d expected 0", Count); end
        checks++; if (Fwd1Valid !== 1'b1 || Fwd1Data !== 32'h1234) begin failures++; $display("FAIL single_fwd_port: got %b/%h expected 1/1234", Fwd1Valid, Fwd1Data); end
        tick();
        checks++; if (RegWre !== 1'b0 || WriteData !== 32'h1234) begin failures++; $display("FAIL single_after: got %b/%h expected 0/1234", RegWre, WriteData); end
        checks++; if (Fwd1Valid !== 1'b0) begin failures++; $display("FAIL single_fwd_gone: got %b expected 0", Fwd1Valid); end
        idle();
    endtask

    task automatic test_dual_push();
        $display("[TB] test_dual_push");
        MemValid = 1'b1; MemReg = 5'd3; MemData = 32'hA;
        AluValid = 1'b1; AluReg = 5'd3; AluData = 32'hB;
        #1;
        checks++; if (MemReady !== 1'b1 || AluReady !== 1'b1) begin failures++; $display("FAIL dual_ready: got %b%b expected 11", MemReady, AluReady); end
        tick();
        MemValid = 1'b0; AluValid = 1'b0;
        ReadReg1 = 5'd3;
        #1;
        checks++; if (Count !== 3'd2) begin failures++; $display("FAIL dual_count: got %0d expected 2", Count); end
        checks++; if (Fwd1Valid !== 1'b1 || Fwd1Data !== 32'hB) begin failures++; $display("FAIL dual_fwd_youngest: got %b/%h expected 1/b", Fwd1Valid, Fwd1Data); end
        tick();
        checks++; if (RegWre !== 1'b1 || WriteData !== 32'hA) begin failures++; $display("FAIL dual_first: got %b/%h expected 1/a", RegWre, WriteData); end
        checks++; if (Fwd1Data !== 32'hB) begin failures++; $display("FAIL dual_fwd_mid: got %h expected b", Fwd1Data); end
        tick();
        checks++; if (RegWre !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'hB) begin failures++; $display("FAIL dual_second: got %b/%0d/%h expected 1/3/b", RegWre, WriteReg, WriteData); end
        tick();
        checks++; if (RegWre !== 1'b0 || Count !== 3'd0) begin failures++; $display("FAIL dual_done: got %b/%0d expected 0/0", RegWre, Count); end
        idle();
    endtask

    task automatic test_full_boundary();
        logic [ADDR_W-1:0] exp_reg [4];
        exp_reg = '{5'd7, 5'd8, 5'd9, 5'd10};
        $display("[TB] test_full_boundary");
        Hold = 1'b1;
        MemValid = 1'b1; MemReg = 5'd7; MemData = 32'h70;
        AluValid = 1'b1; AluReg = 5'd8; AluData = 32'h80;
        tick();
        AluValid = 1'b0;
        MemReg = 5'd9; MemData = 32'h90;
        tick();
        MemReg = 5'd10; MemData = 32'hA0;
        AluValid = 1'b1; AluReg = 5'd11; AluData = 32'hB0;
        #1;
        checks++; if (Count !== 3'd3) begin failures++; $display("FAIL full_pre_count: got %0d expected 3", Count); end
        checks++; if (MemReady !== 1'b1 || AluReady !== 1'b0) begin failures++; $display("FAIL full_last_slot: got %b%b expected 10", MemReady, AluReady); end
        tick();
        checks++; if (Count !== 3'd4) begin failures++; $display("FAIL full_count: got %0d expected 4", Count); end
        checks++; if (MemReady !== 1'b0 || AluReady !== 1'b0) begin failures++; $display("FAIL full_ready: got %b%b expected 00", MemReady, AluReady); end
        ReadReg2 = 5'd10;
        #1;
        checks++; if (Fwd2Valid !== 1'b1 || Fwd2Data !== 32'hA0) begin failures++; $display("FAIL full_fwd_tail: got %b/%h expected 1/a0", Fwd2Valid, Fwd2Data); end
        ReadReg2 = 5'd11;
        #1;
        checks++; if (Fwd2Valid !== 1'b0) begin failures++; $display("FAIL full_fwd_rejected: got %b expected 0", Fwd2Valid); end
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (RegWre !== 1'b1 || WriteReg !== exp_reg[k]) begin failures++; $display("FAIL full_drain_%0d: got %b/%0d expected 1/%0d", k, RegWre, WriteReg, exp_reg[k]); end
        end
        tick();
        checks++; if (RegWre !== 1'b0 || Count !== 3'd0) begin failures++; $display("FAIL full_empty: got %b/%0d expected 0/0", RegWre, Count); end
    endtask

    task automatic test_reg_zero();
        $display("[TB] test_reg_zero");
        AluValid = 1'b1; AluReg = 5'd0; AluData = 32'hFFFF;
        ReadReg1 = 5'd0; ReadReg2 = 5'd0;
        #1;
        checks++; if (AluReady !== 1'b1) begin failures++; $display("FAIL zero_ready: got %b expected 1", AluReady); end
        tick();
        AluValid = 1'b0;
        #1;
        checks++; if (Count !== 3'd0) begin failures++; $display("FAIL zero_count: got %0d expected 0", Count); end
        checks++; if (Fwd1Valid !== 1'b0 || Fwd2Valid !== 1'b0 || Fwd1Data !== 32'd0) begin failures++; $display("FAIL zero_fwd: got %b%b/%h expected 00/0", Fwd1Valid, Fwd2Valid, Fwd1Data); end
        tick();
        checks++; if (RegWre !== 1'b0) begin failures++; $display("FAIL zero_no_write: got %b expected 0", RegWre); end
        idle();
    endtask

    task automatic test_wrap_hold();
        int   next_reg    = 1;
        int   retired     = 0;
        int   model_count = 0;
        int   cyc         = 0;
        logic push;
        logic exp_pop;
        $display("[TB] test_wrap_hold");
        while (retired < 6 && cyc < 40) begin
            Hold = (cyc % 2 == 1);
            if (next_reg <= 6) begin
                MemValid = 1'b1;
                MemReg   = 5'(next_reg);
                MemData  = 32'(next_reg * 16);
            end else begin
                MemValid = 1'b0;
            end
            #1;
            push = MemValid && (model_count < DEPTH);
            if (MemValid) begin
                checks++; if (MemReady !== push) begin failures++; $display("FAIL wrap_ready_c%0d: got %b expected %b", cyc, MemReady, push); end
            end
            exp_pop = !Hold && (model_count > 0);
            tick();
            model_count = model_count + int'(push) - int'(exp_pop);
            if (push) next_reg++;
            checks++; if (RegWre !== exp_pop) begin failures++; $display("FAIL wrap_regwre_c%0d: got %b expected %b", cyc, RegWre, exp_pop); end
            if (exp_pop) begin
                retired++;
                checks++; if (WriteReg !== 5'(retired) || WriteData !== 32'(retired * 16)) begin failures++; $display("FAIL wrap_order_%0d: got %0d/%h expected %0d/%h", retired, WriteReg, WriteData, retired, retired * 16); end
            end
            checks++; if (Count !== CNT_W'(model_count)) begin failures++; $display("FAIL wrap_count_c%0d: got %0d expected %0d", cyc, Count, model_count); end
            cyc++;
        end
        checks++; if (retired != 6) begin failures++; $display("FAIL wrap_timeout: got %0d retired expected 6", retired); end
        idle();
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        Hold = 1'b1;
        MemValid = 1'b1; MemReg = 5'd12; MemData = 32'hC0;
        AluValid = 1'b1; AluReg = 5'd13; AluData = 32'hD0;
        tick();
        AluValid = 1'b0;
        MemReg = 5'd14; MemData = 32'hE0;
        tick();
        MemValid = 1'b0;
        #1;
        checks++; if (Count !== 3'd3) begin failures++; $display("FAIL rstmid_pre: got %0d expected 3", Count); end
        RST = 1'b1;
        Hold = 1'b0;
        tick();
        RST = 1'b0;
        ReadReg1 = 5'd12;
        #1;
        checks++; if (Count !== 3'd0 || RegWre !== 1'b0 || WriteReg !== 5'd0) begin failures++; $display("FAIL rstmid_state: got %0d/%b/%0d expected 0/0/0", Count, RegWre, WriteReg); end
        checks++; if (Fwd1Valid !== 1'b0) begin failures++; $display("FAIL rstmid_fwd: got %b expected 0", Fwd1Valid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (RegWre !== 1'b0) begin failures++; $display("FAIL rstmid_silent_%0d: got %b expected 0", k, RegWre); end
        end
        idle();
    endtask

    initial begin
        RST = 1'b1;
        idle();
        test_reset();
        test_single_write();
        test_dual_push();
        test_full_boundary();
        test_reg_zero();
        test_wrap_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Buffers register-file write requests from the ALU result path and the load/memory path, and retires them in order through the single register-file write port, one per cycle. Also provides forwarding lookups so that rs/rt reads see the youngest pending value for a register before it reaches the register file. Sits between the execute/memory stages and the register file write inputs (RegWre/WriteReg/WriteData).

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_W, 5, register address width
- DATA_W, 32, register data width

- CLK  in  1  clock; all state updates on posedge
- RST  in  1  reset, synchronous, active-high
- MemValid / MemReg / MemData  in  1 / ADDR_W / DATA_W  load-path write request
- MemReady  out  1  load request accepted this cycle when MemValid && MemReady
- AluValid / AluReg / AluData  in  1 / ADDR_W / DATA_W  ALU-path write request
- AluReady  out  1  ALU request accepted this cycle when AluValid && AluReady
- Hold  in  1  1 = do not pop the head this cycle
- RegWre / WriteReg / WriteData  out  1 / ADDR_W / DATA_W  registered drive of the register-file write port
- ReadReg1 / ReadReg2  in  ADDR_W  forwarding lookup addresses
- Fwd1Valid / Fwd1Data, Fwd2Valid / Fwd2Data  out  1 / DATA_W  forwarding result per lookup
- Count  out  $clog2(DEPTH+1)  occupied entries; Full = (Count == DEPTH), Empty = (Count == 0)

## Operation
- Circular buffer with head and tail pointers, each of width log2(DEPTH), wrapping modulo DEPTH. Count is tracked separately.
- Free = DEPTH − Count. Free is computed from the registered Count only; a same-cycle pop does not add space.
- Readiness:
  - MemReady = (Free ≥ 1).
  - AluReady = (Free ≥ 2) || (Free == 1 && !MemValid).
  - Both readies are 0 while RST = 1.
- Enqueue order on simultaneous acceptance: the Mem entry goes in first (it is the older instruction), then the ALU entry. The tail advances by 0, 1 or 2.
- Requests with Reg == 0 are accepted (the handshake completes) but not stored, and Count does not change for them. This matches the register file ignoring writes to register 0.
- Pop: when !Hold && Count > 0, the head entry is popped. On the same edge the output register loads RegWre ← 1, WriteReg ← head.reg, WriteData ← head.data. Otherwise RegWre ← 0, and WriteReg/WriteData hold their previous values.
- Count next = Count + pushes − pop. A push and a pop in the same cycle on a full queue is legal only if the push was accepted; with the rules above that cannot happen when Full.
- Forwarding (combinational, per lookup port):
  - Search queue entries from youngest to oldest, then the output register (only if RegWre = 1).
  - The first match with ReadRegN ≠ 0 sets FwdNValid = 1 and FwdNData = that entry's data.
  - No match, or ReadRegN == 0, gives FwdNValid = 0 and FwdNData = 0.
  - Requests arriving in the same cycle are not forwarded.

## Timing
- Reset values (cycle after RST sampled high): Count 0, head = tail = 0, RegWre 0, WriteReg 0, WriteData 0, Fwd*Valid 0. Queue contents are don't-care because they are masked by Count.
- RST high mid-operation discards all pending entries, and no further RegWre pulse is issued. Reset has priority over push and pop in the same cycle.
- Latency, empty queue with Hold = 0:
  - Request accepted in cycle N.
  - Entry visible to forwarding in cycle N+1, and popped at the end of N+1.
  - RegWre = 1 throughout cycle N+2; the register file commits at the negedge of N+2.
- Throughput is one retire per cycle. Sustained dual-producer input fills the queue at net +1 per cycle.
- Hold asserted for k cycles delays all retirement by k cycles. Order is always preserved.

## Structure
- Package wb_pkg:
  - constants REG_ADDR_W = 5 and DATA_W = 32
  - typedef wb_entry_t {reg: ADDR_W, data: DATA_W}
  - function fwd_match(entry, addr) (address equality with the register-0 exclusion)
- Sub-module wb_fifo: DEPTH-entry circular store with two write ports (ordered) and one read port, exposing its entries for the forwarding search.
- Top writeback_queue contains the handshake/readiness logic, the output register and the forwarding muxes.

## Test plan
- Single write: reset, then MemValid with Reg 5 / Data 0x1234 in cycle 1. Expect RegWre = 1, WriteReg = 5, WriteData = 0x1234 in cycle 3 only, and Count back to 0.
- Dual push ordering: Mem (Reg 3, 0xA) and Alu (Reg 3, 0xB) in the same cycle. Expect RegWre in two consecutive cycles writing 0xA, then 0xB. Fwd1 with ReadReg1 = 3 returns 0xB while both entries are pending.
- Full boundary: Hold = 1, fill to Count = 3 (DEPTH 4), then assert MemValid and AluValid together. Expect MemReady = 1 and AluReady = 0, then Full; both readies 0 on the next cycle.
- Register zero: AluValid with Reg 0, Data 0xFFFF. Expect AluReady = 1, Count unchanged, no RegWre pulse, and Fwd*Valid = 0 for ReadReg = 0.
- Wrap and hold: push 6 entries (Reg 1..6, data = reg × 0x10) with Hold toggling every other cycle. Expect WriteReg to retire 1..6 in order after the pointers wrap.
- Reset mid-stream: 3 entries pending, RST high for one cycle. Expect Count = 0 and RegWre = 0 from the next cycle, with none of the pending entries ever written.
